// File: rtl/qif_spike_monitor.sv
// qif_spike_monitor: spike edge detector, windowed firing-rate counter
// and inter-spike-interval (ISI) meter for the QIF neuron spike output.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   ena        in   monitor enable
//   spike_in   in   neuron spike level (may be held high)
//   win_len    in   [WIN_W-1:0] window length, sampled at window start
//   rate_out   out  [CNT_W-1:0] spike count of last completed window
//   rate_valid out  one-cycle strobe on rate_out update
//   isi_out    out  [ISI_W-1:0] last measured ISI in cycles
//   isi_valid  out  one-cycle strobe on isi_out update
//   burst_out  out  burst flag
//
// Optional feature macro: QIF_MON_BURST_EN
//   defined   : burst_out <= (isi <= BURST_ISI) on every isi_valid
//   undefined : burst_out tied to 0, no comparator

module qif_spike_monitor #(
   parameter int CNT_W     = 8,
   parameter int WIN_W     = 16,
   parameter int ISI_W     = 12,
   parameter int BURST_ISI = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             spike_in,
   input  logic [WIN_W-1:0] win_len,
   output logic [CNT_W-1:0] rate_out,
   output logic             rate_valid,
   output logic [ISI_W-1:0] isi_out,
   output logic             isi_valid,
   output logic             burst_out
);

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
   localparam logic [ISI_W-1:0] ISI_MAX = '1;
   localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);

   state_t           state;
   logic             spike_q;
   logic             spk_edge;
   logic [WIN_W-1:0] wcnt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] cnt_sum;
   logic             win_go;
   logic             win_stop;
   logic             has_ref;
   logic [ISI_W-1:0] isi_cnt;

   // ----------------------------------------------------------------
   // Rising-edge detect: a held-high spike produces a single edge.
   // ----------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spike_q <= 1'b0;
      end else begin
         spike_q <= spike_in;
      end
   end

   assign spk_edge = spike_in & ~spike_q;

   // Count including this cycle's edge, saturating at all-ones.
   always_comb begin
      cnt_sum = count;
      if (spk_edge && (count != CNT_MAX)) begin
         cnt_sum = count + CNT_ONE;
      end
   end

   assign win_go   = ena & (win_len != '0);
   assign win_stop = ~ena | (win_len == '0);

   // ----------------------------------------------------------------
   // Window FSM. wcnt holds the number of window cycles remaining,
   // including the current one, so wcnt==1 marks the last cycle.
   // The edge of the last cycle is folded into the published count,
   // and the next window starts on the following cycle with no gap.
   // ----------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wcnt       <= '0;
         count      <= '0;
         rate_out   <= '0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_go) begin
                  state <= COUNT;
                  wcnt  <= win_len;
                  count <= '0;
               end
            end
            COUNT: begin
               if (win_stop) begin
                  // partial window is dropped silently
                  state <= IDLE;
                  count <= '0;
               end else if (wcnt == WIN_ONE) begin
                  rate_out   <= cnt_sum;
                  rate_valid <= 1'b1;
                  count      <= '0;
                  wcnt       <= win_len;
               end else begin
                  count <= cnt_sum;
                  wcnt  <= wcnt - WIN_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ----------------------------------------------------------------
   // ISI meter. isi_cnt restarts at 1 on the cycle after an edge, so
   // during a later edge cycle it equals the edge-to-edge distance.
   // It saturates rather than wraps for very long silences.
   // ----------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         has_ref   <= 1'b0;
         isi_cnt   <= '0;
         isi_out   <= '0;
         isi_valid <= 1'b0;
      end else if (!ena) begin
         has_ref   <= 1'b0;
         isi_cnt   <= '0;
         isi_valid <= 1'b0;
      end else begin
         isi_valid <= spk_edge & has_ref;
         if (spk_edge) begin
            has_ref <= 1'b1;
            isi_cnt <= ISI_ONE;
            if (has_ref) begin
               isi_out <= isi_cnt;
            end
         end else if (isi_cnt != ISI_MAX) begin
            isi_cnt <= isi_cnt + ISI_ONE;
         end
      end
   end

   // ----------------------------------------------------------------
   // Burst flag: updated alongside isi_out, holds between updates.
   // ----------------------------------------------------------------
`ifdef QIF_MON_BURST_EN
   localparam logic [ISI_W-1:0] BURST_LIM = ISI_W'(BURST_ISI);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         burst_out <= 1'b0;
      end else if (!ena) begin
         burst_out <= 1'b0;
      end else if (spk_edge && has_ref) begin
         burst_out <= (isi_cnt <= BURST_LIM);
      end
   end
`else
   assign burst_out = 1'b0;
`endif

endmodule
